fp_adder_arbiter: RTL
=====================

Name: fp_adder_arbiter

Overview:
- Shares one single-precision floating-point `adder` unit (stb/ack handshake, active-high rst) between n_req requesters, e.g. several column_adder-style accumulators in the coprocessor.
- Uses round-robin arbitration, with one addition in flight at a time.
- Latches each requester's operands, runs the full adder handshake, and returns the result to the granted requester over a valid/ack response.

Parameters:
- n_req, 4, number of requesters.
- cell_width, 32, operand/result width (IEEE-754 single).
- idx_width, 2, width of the grant index; must satisfy 2**idx_width >= n_req.

Ports:
- in_clk  input  1  clock; all state changes on the rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_req_valid  input  n_req  requester i has operands ready; held high until out_req_ack[i].
- in_req_a  input  n_req*cell_width  operand A of requester i, in slice [i*cell_width +: cell_width].
- in_req_b  input  n_req*cell_width  operand B, same slicing as in_req_a.
- out_req_ack  output  n_req  one-cycle pulse; operands of requester i captured.
- out_resp_valid  output  n_req  result ready for requester i; one-hot or zero.
- out_resp_data  output  cell_width  result, valid while any out_resp_valid bit is set.
- in_resp_ack  input  n_req  requester i consumed its result.
- out_add_a, out_add_b  output  cell_width each  operands to the adder.
- out_add_a_stb, out_add_b_stb  output  1 each  adder input strobes.
- out_add_z_ack  output  1  adder output acknowledge.
- out_add_reset  output  1  adder reset, active-high.
- in_add_z  input  cell_width  adder result.
- in_add_z_stb  input  1  adder result valid.
- in_add_a_ack, in_add_b_ack  input  1 each  adder input acknowledges.
- out_busy  output  1  high in every state except s_IDLE.
- out_grant_idx  output  idx_width  index of the current or last granted requester.

Behaviour:
- Reset (in_reset=0, asynchronous):
  - Go to s_IDLE.
  - All outputs 0 except out_add_reset=1.
  - Round-robin pointer last=n_req-1, so requester 0 has first priority.
  - out_grant_idx=0; operand and result latches cleared.
  - Reset during any state aborts the operation; no response is issued.
- States: s_IDLE, s_ISSUE, s_WAIT, s_RESP.
- s_IDLE:
  - out_add_reset=1.
  - If any in_req_valid bit is set, select the first set bit searching last+1, last+2, ... modulo n_req.
  - Latch that requester's a/b, set out_grant_idx, pulse out_req_ack[g] for one cycle, go to s_ISSUE.
  - Otherwise stay in s_IDLE.
- s_ISSUE:
  - out_add_reset=0; drive latched operands; a_stb=b_stb=1.
  - Each strobe drops the cycle after its own ack is sampled high; the two acks may arrive in different cycles.
  - When both have been acked, go to s_WAIT.
- s_WAIT:
  - Hold operands; strobes 0.
  - On in_add_z_stb=1: latch in_add_z, pulse out_add_z_ack for exactly one cycle, go to s_RESP.
- s_RESP:
  - out_resp_valid[g]=1, out_resp_data=latched result, held stable.
  - When in_resp_ack[g]=1: clear valid, set last=g, go to s_IDLE.
  - in_resp_ack bits for requesters other than g are ignored in every state.
- Latency:
  - Request accepted 1 cycle after entering s_IDLE with valid high.
  - Response valid 1 cycle after z_stb is sampled.
  - One dead s_IDLE cycle between consecutive transactions, even if the ack and a new request coincide.
- Fairness: a requester that stays valid is granted within n_req transactions.
- Requester rules:
  - Must hold in_req_valid until acked.
  - Dropping it early is not supported; the arbiter samples only in s_IDLE.
- Arithmetic: no arithmetic in the block; data passes through bit-exact.

Decomposition:
- Shared package (coproc_pkg): state encodings (2-bit s_IDLE=00, s_ISSUE=01, s_WAIT=10, s_RESP=11) and the cell_width default.
- One natural sub-module, rr_pick: combinational round-robin selector with inputs req[n_req] and last[idx_width], outputs grant_idx and any.
  - Reusable by later arbiters, e.g. a shared multiplier.

Test Plan:
- Single request: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0); adder model returns 0x40400000.
  - Expect out_req_ack[0] pulse, a single out_add_z_ack pulse, out_resp_valid=0001 with data 0x40400000 until in_resp_ack[0].
- All four valid simultaneously from reset:
  - Expect grant order 0,1,2,3, then 0 again if still valid.
  - out_req_ack pulses are one-hot and never overlap.
- Staggered adder acks: in_add_a_ack at cycle 2, in_add_b_ack at cycle 5 of s_ISSUE.
  - Expect a_stb low from cycle 3, b_stb low from cycle 6, s_WAIT entered only after both.
- Wrong-requester ack: in s_RESP for g=2, assert in_resp_ack=0001.
  - Expect no change; valid stays 0100 until in_resp_ack[2].
- Reset mid-operation: assert in_reset=0 in s_WAIT.
  - Expect immediate s_IDLE, out_add_reset=1, all resp_valid=0.
  - After release, requester 0 has priority.
- Back-to-back: req1 remains valid while its response is acked.
  - Expect exactly one s_IDLE cycle, then a new out_req_ack[1] pulse (or the next requester in round-robin order if one is valid).

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor's arbiters and arithmetic wrappers.
//
// Contents:
//   cell_width_default : default operand/result width (IEEE-754 single precision)
//   arb_state_t        : state encoding for the shared-unit arbiter FSMs
package coproc_pkg;

    localparam int cell_width_default = 32;

    typedef enum logic [1:0] {
        s_IDLE  = 2'b00,
        s_ISSUE = 2'b01,
        s_WAIT  = 2'b10,
        s_RESP  = 2'b11
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector, reusable by any shared-unit arbiter.
//
// Ports:
//   req       : request vector, one bit per requester
//   last      : index of the most recently served requester
//   grant_idx : first set request bit found searching last+1, last+2, ... modulo n_req
//   any       : high when at least one request bit is set
module rr_pick #(
    parameter int n_req     = 4,
    parameter int idx_width = 2
) (
    input  logic [n_req-1:0]     req,
    input  logic [idx_width-1:0] last,
    output logic [idx_width-1:0] grant_idx,
    output logic                 any
);

    // Walk the offsets from farthest to nearest so that the nearest set bit
    // after 'last' is the one that ends up written.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int i = n_req; i >= 1; i--) begin
            if (req[(int'(last) + i) % n_req]) begin
                grant_idx = idx_width'((int'(last) + i) % n_req);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one floating-point adder (stb/ack handshake) between n_req requesters.
// Round-robin arbitration, one addition in flight at a time.
//
// Ports:
//   in_clk, in_reset             : clock, asynchronous active-low reset
//   in_req_valid/a/b, out_req_ack: requester operand side (ack is a one-cycle pulse)
//   out_resp_valid/data, in_resp_ack : result return to the granted requester
//   out_add_*, in_add_*          : handshake to the shared adder
//   out_busy                     : high whenever not idle
//   out_grant_idx                : current or last granted requester
module fp_adder_arbiter
    import coproc_pkg::*;
#(
    parameter int n_req      = 4,
    parameter int cell_width = cell_width_default,
    parameter int idx_width  = 2
) (
    input  logic                        in_clk,
    input  logic                        in_reset,
    input  logic [n_req-1:0]            in_req_valid,
    input  logic [n_req*cell_width-1:0] in_req_a,
    input  logic [n_req*cell_width-1:0] in_req_b,
    output logic [n_req-1:0]            out_req_ack,
    output logic [n_req-1:0]            out_resp_valid,
    output logic [cell_width-1:0]       out_resp_data,
    input  logic [n_req-1:0]            in_resp_ack,
    output logic [cell_width-1:0]       out_add_a,
    output logic [cell_width-1:0]       out_add_b,
    output logic                        out_add_a_stb,
    output logic                        out_add_b_stb,
    output logic                        out_add_z_ack,
    output logic                        out_add_reset,
    input  logic [cell_width-1:0]       in_add_z,
    input  logic                        in_add_z_stb,
    input  logic                        in_add_a_ack,
    input  logic                        in_add_b_ack,
    output logic                        out_busy,
    output logic [idx_width-1:0]        out_grant_idx
);

    localparam logic [n_req-1:0] one_hot_lsb = n_req'(1);

    arb_state_t            state_q, state_d;
    logic [idx_width-1:0]  last_q, last_d;
    logic [idx_width-1:0]  grant_q, grant_d;
    logic [cell_width-1:0] a_q, a_d;
    logic [cell_width-1:0] b_q, b_d;
    logic [cell_width-1:0] z_q, z_d;
    logic                  a_stb_q, a_stb_d;
    logic                  b_stb_q, b_stb_d;
    logic                  z_ack_q, z_ack_d;
    logic [n_req-1:0]      req_ack_q, req_ack_d;

    logic [idx_width-1:0]  pick_idx;
    logic                  pick_any;

    rr_pick #(
        .n_req     (n_req),
        .idx_width (idx_width)
    ) u_pick (
        .req       (in_req_valid),
        .last      (last_q),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Next-state logic. Both strobes are raised together on leaving idle; each
    // drops independently once its own ack is seen, and the operation moves on
    // only when neither strobe is still outstanding.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        a_d       = a_q;
        b_d       = b_q;
        z_d       = z_q;
        a_stb_d   = 1'b0;
        b_stb_d   = 1'b0;
        z_ack_d   = 1'b0;
        req_ack_d = '0;
        case (state_q)
            s_IDLE: begin
                if (pick_any) begin
                    grant_d   = pick_idx;
                    a_d       = in_req_a[int'(pick_idx)*cell_width +: cell_width];
                    b_d       = in_req_b[int'(pick_idx)*cell_width +: cell_width];
                    req_ack_d = one_hot_lsb << pick_idx;
                    a_stb_d   = 1'b1;
                    b_stb_d   = 1'b1;
                    state_d   = s_ISSUE;
                end
            end
            s_ISSUE: begin
                a_stb_d = a_stb_q && !in_add_a_ack;
                b_stb_d = b_stb_q && !in_add_b_ack;
                if ((!a_stb_q || in_add_a_ack) && (!b_stb_q || in_add_b_ack)) begin
                    state_d = s_WAIT;
                end
            end
            s_WAIT: begin
                if (in_add_z_stb) begin
                    z_d     = in_add_z;
                    z_ack_d = 1'b1;
                    state_d = s_RESP;
                end
            end
            s_RESP: begin
                if (in_resp_ack[grant_q]) begin
                    last_d  = grant_q;
                    state_d = s_IDLE;
                end
            end
            default: state_d = s_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q   <= s_IDLE;
            last_q    <= idx_width'(n_req - 1);
            grant_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            z_q       <= '0;
            a_stb_q   <= 1'b0;
            b_stb_q   <= 1'b0;
            z_ack_q   <= 1'b0;
            req_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            a_q       <= a_d;
            b_q       <= b_d;
            z_q       <= z_d;
            a_stb_q   <= a_stb_d;
            b_stb_q   <= b_stb_d;
            z_ack_q   <= z_ack_d;
            req_ack_q <= req_ack_d;
        end
    end

    // The adder is held in reset while idle so every operation starts clean.
    assign out_add_reset  = (state_q == s_IDLE);
    assign out_busy       = (state_q != s_IDLE);
    assign out_resp_valid = (state_q == s_RESP) ? (one_hot_lsb << grant_q) : '0;
    assign out_resp_data  = z_q;
    assign out_req_ack    = req_ack_q;
    assign out_add_a      = a_q;
    assign out_add_b      = b_q;
    assign out_add_a_stb  = a_stb_q;
    assign out_add_b_stb  = b_stb_q;
    assign out_add_z_ack  = z_ack_q;
    assign out_grant_idx  = grant_q;

endmodule
